uart_frame_ctrl: RTL and testbench

Sequences the byte stream from the UART receiver into framed image-write commands for the downstream write buffer that feeds the SDRAM. It consumes each received byte on its one-cycle valid strobe and validates frame format and checksum. Payload bytes are forwarded as single-cycle write strobes, and each frame ends with a done or error pulse. It sits between the UART receiver and the SDRAM write FIFO/controller.

---
 rtl/uart_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// UART byte-stream framer: validates HDR0 HDR1 CMD LEN P[..] CHK frames and
// forwards payload bytes as single-cycle write strobes with done/err pulses.
module uart_frame_ctrl #(
  parameter logic [7:0]  HDR0    = 8'h55,
  parameter logic [7:0]  HDR1    = 8'hAA,
  parameter logic [15:0] TIMEOUT = 16'd8680
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] rx_data,
  input  logic       po_flag,
  input  logic       wr_full,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic [7:0] cmd,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } state_t;

  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;
  // Counter is tested before it increments, so firing one below the limit
  // lands the abort on the same edge the counter would reach TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd2;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_acc;
  logic [7:0]  r_rem;
  logic [7:0]  r_wr_data;
  logic        r_wr_en;
  logic [7:0]  r_cmd;
  logic [7:0]  r_len;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic        r_busy;

  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_acc_next;
  logic [7:0]  w_rem_next;
  logic [7:0]  w_wr_data_next;
  logic        w_wr_en_next;
  logic [7:0]  w_cmd_next;
  logic [7:0]  w_len_next;
  logic        w_done_next;
  logic        w_err_next;
  logic [1:0]  w_err_code_next;
  logic        w_tmo;

  assign w_tmo = (r_state != ST_IDLE) && !po_flag && (r_cnt == TMO_LAST);

  always_comb begin
    w_state_next    = r_state;
    w_acc_next      = r_acc;
    w_rem_next      = r_rem;
    w_wr_data_next  = r_wr_data;
    w_wr_en_next    = 1'b0;
    w_cmd_next      = r_cmd;
    w_len_next      = r_len;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
    w_err_code_next = r_err_code;

    if (po_flag) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == HDR0) w_state_next = ST_SYNC;
        end
        ST_SYNC: begin
          if (rx_data == HDR1)      w_state_next = ST_CMD;
          else if (rx_data == HDR0) w_state_next = ST_SYNC;
          else                      w_state_next = ST_IDLE;
        end
        ST_CMD: begin
          w_cmd_next   = rx_data;
          w_acc_next   = rx_data;
          w_state_next = ST_LEN;
        end
        ST_LEN: begin
          w_len_next   = rx_data;
          w_acc_next   = r_acc + rx_data;
          w_rem_next   = rx_data;
          w_state_next = (rx_data == 8'd0) ? ST_CHK : ST_DATA;
        end
        ST_DATA: begin
          if (wr_full) begin
            // Byte is dropped; bytes already written stay with the downstream.
            w_err_next      = 1'b1;
            w_err_code_next = ERR_OVF;
            w_state_next    = ST_IDLE;
          end else begin
            w_wr_data_next = rx_data;
            w_wr_en_next   = 1'b1;
            w_acc_next     = r_acc + rx_data;
            w_rem_next     = r_rem - 8'd1;
            if (r_rem == 8'd1) w_state_next = ST_CHK;
          end
        end
        ST_CHK: begin
          if (rx_data == r_acc) begin
            w_done_next = 1'b1;
          end else begin
            w_err_next      = 1'b1;
            w_err_code_next = ERR_CHK;
          end
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else if (w_tmo) begin
      w_state_next = ST_IDLE;
      // A stalled sync pair is not a frame yet, so it dies silently.
      if (r_state != ST_SYNC) begin
        w_err_next      = 1'b1;
        w_err_code_next = ERR_TMO;
      end
    end
  end

  assign w_cnt_next = (po_flag || (r_state == ST_IDLE)) ? 16'd0 : r_cnt + 16'd1;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 16'd0;
      r_acc      <= 8'd0;
      r_rem      <= 8'd0;
      r_wr_data  <= 8'd0;
      r_wr_en    <= 1'b0;
      r_cmd      <= 8'd0;
      r_len      <= 8'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_acc      <= w_acc_next;
      r_rem      <= w_rem_next;
      r_wr_data  <= w_wr_data_next;
      r_wr_en    <= w_wr_en_next;
      r_cmd      <= w_cmd_next;
      r_len      <= w_len_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_err_code <= w_err_code_next;
      r_busy     <= (w_state_next != ST_IDLE);
    end
  end

  assign wr_data    = r_wr_data;
  assign wr_en      = r_wr_en;
  assign cmd        = r_cmd;
  assign frame_len  = r_len;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign err_code   = r_err_code;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: expected strobes/pulses are queued with
// their due cycle as bytes are driven, and matched against the DUT on negedges.
module tb_uart_frame_ctrl;

  localparam logic [15:0] TIMEOUT = 16'd8680;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;
  localparam int K_NONE = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       sclk;
  logic       s_rst_n;
  logic [7:0] rx_data;
  logic       po_flag;
  logic       wr_full;
  logic [7:0] wr_data;
  logic       wr_en;
  logic [7:0] cmd;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  exp_t q[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  uart_frame_ctrl #(.HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT(TIMEOUT)) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .rx_data    (rx_data),
    .po_flag    (po_flag),
    .wr_full    (wr_full),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .cmd        (cmd),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // Drives one byte so it is sampled on the next posedge; bytes sent by
  // consecutive calls land on consecutive clock cycles.
  task automatic send(input logic [7:0] b, input logic full, input int kind, input logic [7:0] d);
    exp_t e;
    @(negedge sclk);
    rx_data = b;
    po_flag = 1'b1;
    wr_full = full;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.data = d;
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
    @(posedge sclk);
    #1;
    po_flag = 1'b0;
    wr_full = 1'b0;
  endtask

  // Scoreboard: every strobe/pulse must match the head of the queue at its due cycle.
  always @(negedge sclk) begin : monitor
    exp_t e;
    if (s_rst_n) begin
      if (frame_done && frame_err) begin
        vectors++; miscompares++;
        $display("FAIL pulse_excl: done=%0b err=%0b both high at cycle %0d", frame_done, frame_err, cyc);
      end
      if (wr_en) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_wr: wr_data=%02h at cycle %0d, nothing expected", wr_data, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind !== K_WR || e.data !== wr_data || e.cyc != cyc) begin
            miscompares++;
            $display("FAIL wr: got wr_data=%02h cyc=%0d, expected kind=%0d data=%02h cyc=%0d",
                     wr_data, cyc, e.kind, e.data, e.cyc);
          end
        end
      end
      if (frame_done) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: frame_done at cycle %0d, nothing expected", cyc);
        end else begin
          e = q.pop_front();
          if (e.kind !== K_DONE || e.cyc != cyc) begin
            miscompares++;
            $display("FAIL done: got frame_done cyc=%0d, expected kind=%0d cyc=%0d", cyc, e.kind, e.cyc);
          end
        end
      end
      if (frame_err) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_err: frame_err code=%0d at cycle %0d, nothing expected", err_code, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind !== K_ERR || {6'd0, err_code} !== e.data || e.cyc != cyc) begin
            miscompares++;
            $display("FAIL err: got code=%0d cyc=%0d, expected kind=%0d code=%0d cyc=%0d",
                     err_code, cyc, e.kind, e.data, e.cyc);
          end
        end
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing: kind=%0d data=%02h due cycle %0d not seen by %0d", e.kind, e.data, e.cyc, cyc);
      end
    end
  end

  task automatic settle_and_check(input string name, input logic [7:0] exp_cmd,
                                  input logic [7:0] exp_len, input logic [1:0] exp_code);
    repeat (3) @(negedge sclk);
    vectors++;
    if (q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_queue: %0d expected events outstanding, required 0", name, q.size());
    end
    vectors++;
    if ({cmd, frame_len, err_code, busy} !== {exp_cmd, exp_len, exp_code, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_regs: cmd=%02h len=%02h code=%0d busy=%0b, required %02h %02h %0d 0",
               name, cmd, frame_len, err_code, busy, exp_cmd, exp_len, exp_code);
    end
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0; rx_data = 8'h00; po_flag = 1'b0; wr_full = 1'b0;
    repeat (3) @(negedge sclk);
    vectors++;
    if ({wr_data, wr_en, cmd, frame_len, frame_done, frame_err, err_code, busy} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: wr_data=%02h wr_en=%0b cmd=%02h len=%02h done=%0b err=%0b code=%0d busy=%0b, required all 0",
               wr_data, wr_en, cmd, frame_len, frame_done, frame_err, err_code, busy);
    end
    s_rst_n = 1'b1;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_good_frame();
    logic [7:0] p[3];
    logic [7:0] sum;
    p = '{8'h10, 8'h20, 8'h30};
    sum = 8'h01 + 8'h03;
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL good_busy: busy=%0b mid-frame, required 1", busy);
    end
    send(8'h01, 1'b0, K_NONE, 8'h00);
    send(8'h03, 1'b0, K_NONE, 8'h00);
    for (int i = 0; i < 3; i++) begin
      send(p[i], 1'b0, K_WR, p[i]);
      sum = sum + p[i];
    end
    send(sum, 1'b0, K_DONE, 8'h00);
    $display("good frame sent, chk=%02h", sum);
    settle_and_check("good", 8'h01, 8'h03, 2'd0);
  endtask

  task automatic test_bad_checksum();
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h01, 1'b0, K_NONE, 8'h00);
    send(8'h03, 1'b0, K_NONE, 8'h00);
    send(8'h10, 1'b0, K_WR, 8'h10);
    send(8'h20, 1'b0, K_WR, 8'h20);
    send(8'h30, 1'b0, K_WR, 8'h30);
    send(8'h65, 1'b0, K_ERR, 8'd1);
    $display("bad checksum frame sent");
    settle_and_check("badchk", 8'h01, 8'h03, 2'd1);
  endtask

  task automatic test_zero_len_resync();
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h02, 1'b0, K_NONE, 8'h00);
    send(8'h00, 1'b0, K_NONE, 8'h00);
    send(8'h02, 1'b0, K_DONE, 8'h00);
    $display("zero-length frame with resync sent");
    settle_and_check("zerolen", 8'h02, 8'h00, 2'd1);
  endtask

  task automatic test_timeout();
    int n0;
    logic [7:0] sum;
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h01, 1'b0, K_NONE, 8'h00);
    send(8'h04, 1'b0, K_NONE, 8'h00);
    send(8'h11, 1'b0, K_WR, 8'h11);
    n0 = cyc;
    begin
      exp_t e;
      e.kind = K_ERR; e.data = 8'd2; e.cyc = n0 + int'(TIMEOUT) - 1;
      q.push_back(e);
    end
    repeat (int'(TIMEOUT) + 5) @(negedge sclk);
    $display("timeout frame idled %0d cycles", int'(TIMEOUT) + 5);
    settle_and_check("timeout", 8'h01, 8'h04, 2'd2);

    // Same frame, but each late byte arrives on the last allowed cycle.
    sum = 8'h01 + 8'h04 + 8'h11;
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h01, 1'b0, K_NONE, 8'h00);
    send(8'h04, 1'b0, K_NONE, 8'h00);
    send(8'h11, 1'b0, K_WR, 8'h11);
    repeat (int'(TIMEOUT) - 2) @(negedge sclk);
    send(8'h22, 1'b0, K_WR, 8'h22);
    sum = sum + 8'h22;
    send(8'h33, 1'b0, K_WR, 8'h33);
    sum = sum + 8'h33;
    send(8'h44, 1'b0, K_WR, 8'h44);
    sum = sum + 8'h44;
    send(sum, 1'b0, K_DONE, 8'h00);
    $display("boundary-timing frame sent, chk=%02h", sum);
    settle_and_check("tmo_edge", 8'h01, 8'h04, 2'd2);
  endtask

  task automatic test_overflow();
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h01, 1'b0, K_NONE, 8'h00);
    send(8'h02, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_WR, 8'hAA);
    send(8'hBB, 1'b1, K_ERR, 8'd3);
    send(8'h68, 1'b0, K_NONE, 8'h00);
    $display("overflow frame sent");
    settle_and_check("overflow", 8'h01, 8'h02, 2'd3);
  endtask

  task automatic test_reset_mid_frame();
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h09, 1'b0, K_NONE, 8'h00);
    send(8'h05, 1'b0, K_NONE, 8'h00);
    send(8'h10, 1'b0, K_WR, 8'h10);
    @(negedge sclk);
    #2;
    s_rst_n = 1'b0;
    #1;
    vectors++;
    if ({wr_data, wr_en, cmd, frame_len, frame_done, frame_err, err_code, busy} !== 29'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: wr_data=%02h wr_en=%0b cmd=%02h len=%02h code=%0d busy=%0b, required all 0",
               wr_data, wr_en, cmd, frame_len, err_code, busy);
    end
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h07, 1'b0, K_NONE, 8'h00);
    send(8'h01, 1'b0, K_NONE, 8'h00);
    send(8'hFF, 1'b0, K_WR, 8'hFF);
    send(8'h07, 1'b0, K_DONE, 8'h00);
    $display("frame after mid-frame reset sent");
    settle_and_check("midreset", 8'h07, 8'h01, 2'd0);
  endtask

  task automatic test_back_to_back();
    // CHK of frame A is immediately followed by HDR0 of frame B.
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h03, 1'b0, K_NONE, 8'h00);
    send(8'h01, 1'b0, K_NONE, 8'h00);
    send(8'h40, 1'b0, K_WR, 8'h40);
    send(8'h44, 1'b0, K_DONE, 8'h00);
    send(8'h55, 1'b0, K_NONE, 8'h00);
    send(8'hAA, 1'b0, K_NONE, 8'h00);
    send(8'h80, 1'b0, K_NONE, 8'h00);
    send(8'h02, 1'b0, K_NONE, 8'h00);
    send(8'hF0, 1'b0, K_WR, 8'hF0);
    send(8'h0F, 1'b0, K_WR, 8'h0F);
    send(8'h81, 1'b0, K_DONE, 8'h00);
    $display("back-to-back frames sent");
    settle_and_check("b2b", 8'h80, 8'h02, 2'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_len_resync();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
